// File: rtl/inst_buffer_flow_ctrl_pkg.sv
// Shared sizing defaults and FSM encoding for the instruction-buffer flow controller.
// Pure declarations: no latency, no flow control.
package inst_buffer_flow_ctrl_pkg;

  localparam int IB_FETCH_WIDTH    = 8;
  localparam int IB_DISPATCH_WIDTH = 4;
  localparam int IB_DEPTH          = 32;
  localparam int IB_DEPTH_LOG      = 5;
  localparam int IB_FLUSH_BUBBLE   = 2;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } ibState_e;

endpackage

// File: rtl/lane_compact_offset.sv
// Prefix popcount over a lane-valid vector: each lane's slot offset plus the total valid count.
// Purely combinational (0 cycles); no back-pressure, shared with the active-list allocator.
module lane_compact_offset
  import inst_buffer_flow_ctrl_pkg::*;
#(
  parameter int LANES = IB_FETCH_WIDTH,
  parameter int OFF_W = $clog2(LANES) + 1
) (
  input  logic [LANES-1:0]            laneVector,
  output logic [LANES-1:0][OFF_W-1:0] laneOffset,
  output logic [OFF_W-1:0]            laneTotal
);

  logic [OFF_W-1:0] runSum;

  // Lane k lands after every valid lane below it, so holes in the vector collapse.
  always_comb begin
    runSum     = '0;
    laneOffset = '0;
    for (int k = 0; k < LANES; k++) begin
      laneOffset[k] = runSum;
      runSum        = runSum + OFF_W'(laneVector[k]);
    end
    laneTotal = runSum;
  end

endmodule

// File: rtl/inst_buffer_flow_ctrl.sv
// Head/tail/occupancy control for the decode->dispatch instruction buffer; writes land 1 cycle before they are dispatchable.
// Fetch is held when a full bundle might not fit or during the post-flush bubble; dispatch waits on stall_i and a full group.
module inst_buffer_flow_ctrl
  import inst_buffer_flow_ctrl_pkg::*;
#(
  parameter int FETCH_WIDTH    = IB_FETCH_WIDTH,
  parameter int DISPATCH_WIDTH = IB_DISPATCH_WIDTH,
  parameter int DEPTH          = IB_DEPTH,
  parameter int DEPTH_LOG      = IB_DEPTH_LOG,
  parameter int FLUSH_BUBBLE   = IB_FLUSH_BUBBLE
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush_i,
  input  logic                             stall_i,
  input  logic                             decodeReady_i,
  input  logic [FETCH_WIDTH-1:0]           decodedVector_i,
  output logic [FETCH_WIDTH-1:0]           writeEnable_o,
  output logic [FETCH_WIDTH*DEPTH_LOG-1:0] writeAddr_o,
  output logic [DEPTH_LOG-1:0]             readAddrBase_o,
  output logic                             instBufferReady_o,
  output logic                             dispatch_o,
  output logic                             stallFetch_o,
  output logic [DEPTH_LOG:0]               instCount_o
);

  localparam int LANE_W = $clog2(FETCH_WIDTH) + 1;
  localparam int CNT_W  = DEPTH_LOG + 1;
  localparam int BUB_W  = (FLUSH_BUBBLE > 1) ? $clog2(FLUSH_BUBBLE) : 1;

  localparam logic [CNT_W-1:0]     STALL_LEVEL = CNT_W'(DEPTH - FETCH_WIDTH);
  localparam logic [CNT_W-1:0]     GROUP       = CNT_W'(DISPATCH_WIDTH);
  localparam logic [DEPTH_LOG-1:0] HEAD_STEP   = DEPTH_LOG'(DISPATCH_WIDTH);
  localparam logic [BUB_W-1:0]     BUB_LOAD    = BUB_W'(FLUSH_BUBBLE - 1);

  ibState_e             state, stateNext;
  logic [BUB_W-1:0]     bubbleCnt, bubbleCntNext;
  logic [DEPTH_LOG-1:0] head, tail;
  logic [CNT_W-1:0]     count;

  logic [FETCH_WIDTH-1:0][LANE_W-1:0] laneOffset;
  logic [LANE_W-1:0]                  laneTotal;
  logic                               accept;
  logic [CNT_W-1:0]                   nIn;

  lane_compact_offset #(
    .LANES (FETCH_WIDTH),
    .OFF_W (LANE_W)
  ) uLaneOffset (
    .laneVector (decodedVector_i),
    .laneOffset (laneOffset),
    .laneTotal  (laneTotal)
  );

  // Threshold leaves room for a whole bundle, so count can never pass DEPTH.
  assign stallFetch_o      = (state == RECOVER) | (count > STALL_LEVEL);
  // Reset also masks the write ports so nothing strobes the SRAM while held.
  assign accept            = reset & decodeReady_i & ~stallFetch_o & ~flush_i;
  assign writeEnable_o     = {FETCH_WIDTH{accept}} & decodedVector_i;
  assign nIn               = accept ? CNT_W'(laneTotal) : '0;

  assign instBufferReady_o = (state == RUN) & (count >= GROUP);
  assign dispatch_o        = instBufferReady_o & ~stall_i & ~flush_i;

  assign readAddrBase_o    = head;
  assign instCount_o       = count;

  always_comb begin
    writeAddr_o = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      writeAddr_o[k*DEPTH_LOG +: DEPTH_LOG] = tail + DEPTH_LOG'(laneOffset[k]);
    end
  end

  always_comb begin
    stateNext     = state;
    bubbleCntNext = bubbleCnt;
    if (flush_i) begin
      stateNext     = RECOVER;
      bubbleCntNext = BUB_LOAD;
    end else if (state == RECOVER) begin
      if (bubbleCnt == '0) begin
        stateNext = RUN;
      end else begin
        bubbleCntNext = bubbleCnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      bubbleCnt <= '0;
    end else begin
      state     <= stateNext;
      bubbleCnt <= bubbleCntNext;
    end
  end

  // A same-cycle write and dispatch is fine: the group read is already resident.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + DEPTH_LOG'(nIn);
      if (dispatch_o) begin
        head <= head + HEAD_STEP;
      end
      count <= count + nIn - (dispatch_o ? GROUP : '0);
    end
  end

endmodule

// File: tb/tb_inst_buffer_flow_ctrl.sv
// Directed bench for inst_buffer_flow_ctrl: an occupancy/queue model checked every cycle plus literal pins.
module tb_inst_buffer_flow_ctrl;

  localparam int FW    = 8;
  localparam int DW    = 4;
  localparam int DEPTH = 32;
  localparam int DL    = 5;
  localparam int FB    = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            flush_i = 1'b0;
  logic            stall_i = 1'b0;
  logic            decodeReady_i = 1'b0;
  logic [FW-1:0]   decodedVector_i = '0;
  logic [FW-1:0]   writeEnable_o;
  logic [FW*DL-1:0] writeAddr_o;
  logic [DL-1:0]   readAddrBase_o;
  logic            instBufferReady_o;
  logic            dispatch_o;
  logic            stallFetch_o;
  logic [DL:0]     instCount_o;

  always #5 clk = ~clk;

  inst_buffer_flow_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .flush_i           (flush_i),
    .stall_i           (stall_i),
    .decodeReady_i     (decodeReady_i),
    .decodedVector_i   (decodedVector_i),
    .writeEnable_o     (writeEnable_o),
    .writeAddr_o       (writeAddr_o),
    .readAddrBase_o    (readAddrBase_o),
    .instBufferReady_o (instBufferReady_o),
    .dispatch_o        (dispatch_o),
    .stallFetch_o      (stallFetch_o),
    .instCount_o       (instCount_o)
  );

  int checks = 0;
  int errors = 0;

  // Model: the buffer is "mOcc entries starting at mHead"; recovery is a count of forced-stall cycles left.
  int mHead = 0;
  int mOcc = 0;
  int mRecover = 0;
  int eNIn = 0;
  bit eDisp = 1'b0;
  bit eFlush = 1'b0;

  int   bubbleLen;
  logic sawStall;

  logic [7:0] tVec [8] = '{8'hFF, 8'h55, 8'h00, 8'hC3, 8'h81, 8'hFF, 8'h0E, 8'hFF};
  bit         tStall [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic modelCheck();
    int tailP;
    int pre;
    bit eStall;
    bit acc;
    bit eReady;
    logic [FW-1:0] eWe;
    logic [FW*DL-1:0] eAddr;
    tailP  = (mHead + mOcc) % DEPTH;
    eStall = (mRecover > 0) || (mOcc > DEPTH - FW);
    acc    = decodeReady_i && !eStall && !flush_i;
    eWe    = acc ? decodedVector_i : '0;
    pre    = 0;
    eAddr  = '0;
    for (int k = 0; k < FW; k++) begin
      eAddr[k*DL +: DL] = DL'((tailP + pre) % DEPTH);
      if (decodedVector_i[k]) pre++;
    end
    eNIn   = acc ? pre : 0;
    eReady = (mRecover == 0) && (mOcc >= DW);
    eDisp  = eReady && !stall_i && !flush_i;
    eFlush = flush_i;
    chk("stallFetch", 64'(stallFetch_o), 64'(eStall));
    chk("writeEnable", 64'(writeEnable_o), 64'(eWe));
    chk("writeAddr", 64'(writeAddr_o), 64'(eAddr));
    chk("ready", 64'(instBufferReady_o), 64'(eReady));
    chk("dispatch", 64'(dispatch_o), 64'(eDisp));
    chk("count", 64'(instCount_o), 64'(mOcc));
    chk("head", 64'(readAddrBase_o), 64'(mHead));
    chk("countBound", 64'(instCount_o <= DEPTH), 64'd1);
  endtask

  task automatic modelEdge();
    if (eFlush) begin
      mHead    = 0;
      mOcc     = 0;
      mRecover = FB;
    end else begin
      mOcc  = mOcc + eNIn - (eDisp ? DW : 0);
      mHead = (mHead + (eDisp ? DW : 0)) % DEPTH;
      if (mRecover > 0) mRecover--;
    end
  endtask

  task automatic apply(input logic dr, input logic [FW-1:0] vec, input logic st, input logic fl);
    decodeReady_i   = dr;
    decodedVector_i = vec;
    stall_i         = st;
    flush_i         = fl;
    @(negedge clk);
    modelCheck();
  endtask

  task automatic advance();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic cyc(input logic dr, input logic [FW-1:0] vec, input logic st, input logic fl);
    apply(dr, vec, st, fl);
    advance();
  endtask

  task automatic flushAndDrainBubble();
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_writeEnable", 64'(writeEnable_o), 64'd0);
    chk("rst_ready", 64'(instBufferReady_o), 64'd0);
    chk("rst_dispatch", 64'(dispatch_o), 64'd0);
    chk("rst_stallFetch", 64'(stallFetch_o), 64'd0);
    chk("rst_count", 64'(instCount_o), 64'd0);
    chk("rst_head", 64'(readAddrBase_o), 64'd0);
    reset = 1'b1;

    // Full bundle, then dispatch of the first group.
    apply(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("t1_addrLane0", 64'(writeAddr_o[0*DL +: DL]), 64'd0);
    chk("t1_addrLane7", 64'(writeAddr_o[7*DL +: DL]), 64'd7);
    advance();
    chk("t1_count8", 64'(instCount_o), 64'd8);
    chk("t1_ready", 64'(instBufferReady_o), 64'd1);
    apply(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t1_dispatch", 64'(dispatch_o), 64'd1);
    advance();
    chk("t1_head4", 64'(readAddrBase_o), 64'd4);
    chk("t1_count4", 64'(instCount_o), 64'd4);

    // Walk tail to 30 while dispatching, then a sparse bundle across the wrap.
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 8'h3F, 1'b0, 1'b0);
    chk("t2_count14", 64'(instCount_o), 64'd14);
    apply(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("t2_enables", 64'(writeEnable_o), 64'hA5);
    chk("t2_addrLane0", 64'(writeAddr_o[0*DL +: DL]), 64'd30);
    chk("t2_addrLane2", 64'(writeAddr_o[2*DL +: DL]), 64'd31);
    chk("t2_addrLane5", 64'(writeAddr_o[5*DL +: DL]), 64'd0);
    chk("t2_addrLane7", 64'(writeAddr_o[7*DL +: DL]), 64'd1);
    advance();
    chk("t2_count18", 64'(instCount_o), 64'd18);

    // Fill to the stall threshold and beyond with the back-end stalled.
    flushAndDrainBubble();
    chk("t3_bubbleOver", 64'(stallFetch_o), 64'd0);
    cyc(1'b1, 8'hFF, 1'b1, 1'b0);
    cyc(1'b1, 8'hFF, 1'b1, 1'b0);
    cyc(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("t3_count24", 64'(instCount_o), 64'd24);
    chk("t3_noStallAt24", 64'(stallFetch_o), 64'd0);
    cyc(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("t3_count32", 64'(instCount_o), 64'd32);
    chk("t3_stallAt32", 64'(stallFetch_o), 64'd1);
    apply(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("t3_ignored", 64'(writeEnable_o), 64'd0);
    advance();
    chk("t3_countHeld", 64'(instCount_o), 64'd32);

    // Partial group is never dispatched.
    flushAndDrainBubble();
    cyc(1'b1, 8'h07, 1'b0, 1'b0);
    apply(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t4_readyAt3", 64'(instBufferReady_o), 64'd0);
    chk("t4_noDispatch", 64'(dispatch_o), 64'd0);
    advance();
    apply(1'b1, 8'h80, 1'b0, 1'b0);
    chk("t4_addrLane7", 64'(writeAddr_o[7*DL +: DL]), 64'd3);
    advance();
    chk("t4_count4", 64'(instCount_o), 64'd4);
    chk("t4_readyAt4", 64'(instBufferReady_o), 64'd1);

    // Flush with a concurrent full write; measure the fetch bubble.
    cyc(1'b1, 8'hFF, 1'b1, 1'b0);
    cyc(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("t5_count20", 64'(instCount_o), 64'd20);
    apply(1'b1, 8'hFF, 1'b0, 1'b1);
    chk("t5_writeSuppressed", 64'(writeEnable_o), 64'd0);
    chk("t5_dispatchSuppressed", 64'(dispatch_o), 64'd0);
    advance();
    chk("t5_countFlushed", 64'(instCount_o), 64'd0);
    chk("t5_headFlushed", 64'(readAddrBase_o), 64'd0);
    bubbleLen = 0;
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 8'h00, 1'b1, 1'b0);
      sawStall = stallFetch_o;
      advance();
      if (sawStall) bubbleLen++;
      else break;
    end
    chk("t5_bubbleLen", 64'(bubbleLen), 64'(FB));

    // Asynchronous reset mid-stream.
    cyc(1'b1, 8'hFF, 1'b1, 1'b0);
    cyc(1'b1, 8'h0F, 1'b1, 1'b0);
    chk("t6_count12", 64'(instCount_o), 64'd12);
    decodeReady_i   = 1'b1;
    decodedVector_i = 8'hFF;
    stall_i         = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("t6_writeEnable", 64'(writeEnable_o), 64'd0);
    chk("t6_ready", 64'(instBufferReady_o), 64'd0);
    chk("t6_dispatch", 64'(dispatch_o), 64'd0);
    chk("t6_stallFetch", 64'(stallFetch_o), 64'd0);
    chk("t6_count", 64'(instCount_o), 64'd0);
    chk("t6_head", 64'(readAddrBase_o), 64'd0);
    mHead    = 0;
    mOcc     = 0;
    mRecover = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("t6_resumeEnables", 64'(writeEnable_o), 64'hFF);
    advance();
    chk("t6_resumeCount", 64'(instCount_o), 64'd8);

    // Back-to-back flushes, then a mixed pattern table under the model.
    cyc(1'b1, 8'hFF, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, tVec[i], tStall[i], 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
